// File: rtl/hist_acc_bank.sv
// Double-buffered per-channel accumulator bank: live sums snapshot on frame_end and drain over valid/ready.
// Optional saturation: define HIST_ACC_SAT_EN to clamp instead of wrap and track per-channel sat bits.
module hist_acc_bank #(
  parameter  int DATA_WIDTH = 14,
  parameter  int ACC_WIDTH  = 24,
  parameter  int N_CH       = 8,
  localparam int CH_W       = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  in_valid,
  input  logic [CH_W-1:0]       in_ch,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  clear,
  input  logic                  frame_end,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CH_W-1:0]       out_ch,
  output logic [ACC_WIDTH-1:0]  out_data,
  output logic                  out_sat,
  output logic                  out_last,
  output logic                  busy,
  output logic                  overrun
);

  typedef enum logic {IDLE, DUMP} state_t;

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  state_t               state_q;
  logic [CH_W-1:0]      idx_q;
  logic                 overrun_q;
  logic [ACC_WIDTH-1:0] acc_q [N_CH];
  logic [ACC_WIDTH-1:0] acc_d [N_CH];
  logic [ACC_WIDTH-1:0] shd_q [N_CH];
  logic                 hit;
  logic                 fe_take;
  logic                 fe_drop;
`ifdef HIST_ACC_SAT_EN
  logic [N_CH-1:0]      sat_q;
  logic [N_CH-1:0]      sat_d;
  logic [N_CH-1:0]      shsat_q;
`endif

  // Carry-out in the top bit so the caller can detect overflow.
  function automatic logic [ACC_WIDTH:0] add_ext(input logic [ACC_WIDTH-1:0] acc,
                                                 input logic [DATA_WIDTH-1:0] inc);
    return {1'b0, acc} + (ACC_WIDTH+1)'(inc);
  endfunction

  function automatic logic [ACC_WIDTH-1:0] sat_clamp(input logic [ACC_WIDTH:0] sum);
    return sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
  endfunction

  assign hit     = in_valid && (int'(in_ch) < N_CH);
  assign fe_take = frame_end && !clear && (state_q == IDLE);
  assign fe_drop = frame_end && !clear && (state_q == DUMP);

  // Post-increment view of every channel; also the snapshot source so a same-cycle sample is kept.
  always_comb begin
    logic [DATA_WIDTH-1:0] inc;
    logic [ACC_WIDTH:0]    sum;
    for (int i = 0; i < N_CH; i++) begin
      inc = (hit && (in_ch == CH_W'(i))) ? in_data : '0;
      sum = add_ext(acc_q[i], inc);
`ifdef HIST_ACC_SAT_EN
      acc_d[i] = sat_clamp(sum);
      sat_d[i] = sat_q[i] | sum[ACC_WIDTH];
`else
      acc_d[i] = sum[ACC_WIDTH-1:0];
`endif
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        acc_q[i] <= '0;
        shd_q[i] <= '0;
      end
`ifdef HIST_ACC_SAT_EN
      sat_q   <= '0;
      shsat_q <= '0;
`endif
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        acc_q[i] <= (clear || fe_take) ? '0 : acc_d[i];
        if (fe_take) shd_q[i] <= acc_d[i];
      end
`ifdef HIST_ACC_SAT_EN
      sat_q <= (clear || fe_take) ? '0 : sat_d;
      if (fe_take) shsat_q <= sat_d;
`endif
      if (clear)        overrun_q <= 1'b0;
      else if (fe_drop) overrun_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (fe_take) begin
            state_q <= DUMP;
            idx_q   <= '0;
          end
        end
        DUMP: begin
          if (out_ready) begin
            if (idx_q == LAST_CH) begin
              state_q <= IDLE;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q == DUMP);
  assign out_valid = busy;
  assign out_ch    = busy ? idx_q : '0;
  assign out_data  = busy ? shd_q[idx_q] : '0;
  assign out_last  = busy && (idx_q == LAST_CH);
  assign overrun   = overrun_q;
`ifdef HIST_ACC_SAT_EN
  assign out_sat   = busy && shsat_q[idx_q];
`else
  assign out_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_hist_acc_bank.sv
// Directed bench for hist_acc_bank (ACC_WIDTH=16, DATA_WIDTH=14, N_CH=8).
module tb_hist_acc_bank;

  localparam int DW = 14;
  localparam int AW = 16;
  localparam int NC = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          arstn = 1'b0;
  logic          in_valid = 1'b0;
  logic [CW-1:0] in_ch = '0;
  logic [DW-1:0] in_data = '0;
  logic          clear = 1'b0;
  logic          frame_end = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [CW-1:0] out_ch;
  logic [AW-1:0] out_data;
  logic          out_sat;
  logic          out_last;
  logic          busy;
  logic          overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_d [NC];
  int exp_s [NC];

  hist_acc_bank #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .N_CH(NC)) dut (
    .clk(clk), .arstn(arstn), .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
    .clear(clear), .frame_end(frame_end), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_data(out_data), .out_sat(out_sat), .out_last(out_last),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int ch, input int val);
    in_valid = 1'b1;
    in_ch    = CW'(ch);
    in_data  = DW'(val);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic fend();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
  endtask

  task automatic exp_zero();
    for (int i = 0; i < NC; i++) begin
      exp_d[i] = 0;
      exp_s[i] = 0;
    end
  endtask

  // Walks one full drain; stall=1 holds out_ready low on every other cycle.
  task automatic drain(input bit stall);
    int got = 0;
    int cyc = 0;
    bit rdy;
    while (got < NC) begin
      if (cyc >= 64) begin
        check("drain_timeout", got, NC);
        break;
      end
      if (!out_valid) begin
        check("drain_valid", 0, 1);
        break;
      end
      check("drain_ch", int'(out_ch), got);
      check("drain_data", int'(out_data), exp_d[got]);
      check("drain_last", int'(out_last), (got == NC - 1) ? 1 : 0);
      check("drain_sat", int'(out_sat), exp_s[got]);
      rdy = stall ? (cyc % 2 == 1) : 1'b1;
      out_ready = rdy;
      tick();
      if (rdy) got++;
      cyc++;
    end
    out_ready = 1'b1;
    check("after_valid", int'(out_valid), 0);
    check("after_busy", int'(busy), 0);
  endtask

  initial begin
    #12;
    check("rst_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_data", int'(out_data), 0);
    arstn = 1'b1;
    tick();

    // Basic accumulate and drain
    add(2, 5); add(2, 5); add(2, 5); add(7, 100);
    fend();
    check("fe_ch0_valid", int'(out_valid), 1);
    exp_zero(); exp_d[2] = 15; exp_d[7] = 100;
    drain(1'b0);

    // Backpressure
    add(0, 1); add(3, 9); add(5, 4);
    fend();
    exp_zero(); exp_d[0] = 1; exp_d[3] = 9; exp_d[5] = 4;
    drain(1'b1);

    // Sample coincident with frame_end lands in the snapshot
    in_valid = 1'b1; in_ch = 3'd1; in_data = 14'd3; frame_end = 1'b1;
    tick();
    in_valid = 1'b0; frame_end = 1'b0;
    exp_zero(); exp_d[1] = 3;
    drain(1'b0);
    fend();
    exp_zero();
    drain(1'b0);

    // clear beats in_valid and frame_end
    add(4, 7);
    clear = 1'b1; in_valid = 1'b1; in_ch = 3'd4; in_data = 14'd2; frame_end = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0; frame_end = 1'b0;
    check("clr_busy", int'(busy), 0);
    check("clr_valid", int'(out_valid), 0);
    fend();
    exp_zero();
    drain(1'b0);

    // Overrun while stalled
    out_ready = 1'b0;
    add(6, 10);
    fend();
    add(6, 20);
    fend();
    check("ovr_set", int'(overrun), 1);
    check("ovr_valid", int'(out_valid), 1);
    check("ovr_ch", int'(out_ch), 0);
    add(6, 5);
    exp_zero(); exp_d[6] = 10;
    drain(1'b0);
    check("ovr_sticky", int'(overrun), 1);
    fend();
    exp_zero(); exp_d[6] = 25;
    drain(1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("ovr_clear", int'(overrun), 0);

    // Width boundary
    for (int k = 0; k < 5; k++) add(0, 16383);
    fend();
    exp_zero();
`ifdef HIST_ACC_SAT_EN
    exp_d[0] = 65535; exp_s[0] = 1;
`else
    exp_d[0] = 16379; exp_s[0] = 0;
`endif
    drain(1'b0);

    // Reset mid-drain
    add(3, 50);
    fend();
    in_valid = 1'b1; in_ch = 3'd5; in_data = 14'd8; frame_end = 1'b1;
    tick();
    in_valid = 1'b0; frame_end = 1'b0;
    tick(); tick();
    check("mid_ch", int'(out_ch), 3);
    check("mid_overrun", int'(overrun), 1);
    arstn = 1'b0;
    #1;
    check("arst_valid", int'(out_valid), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_overrun", int'(overrun), 0);
    #10;
    arstn = 1'b1;
    tick();
    fend();
    exp_zero();
    drain(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hist_acc_bank.md
# hist_acc_bank

Multi-channel, double-buffered accumulator bank for the histogram counting path. Sums per-channel increments into a live bank of N_CH accumulators. On a frame boundary it snapshots the live bank into a shadow bank, zeroes the live bank, and drains the snapshot one channel per beat over a valid/ready stream. Accumulation continues without gaps while the drain runs.

## Interface
- DATA_WIDTH, 14, width of each input increment (unsigned)
- ACC_WIDTH, 24, width of each accumulator; must be ≥ DATA_WIDTH
- N_CH, 8, channel count, ≥ 2; CH_W = $clog2(N_CH) is a derived localparam
- clk  input  1  clock, rising edge
- arstn  input  1  reset; asynchronous, active-low
- in_valid  input  1  increment present this cycle
- in_ch  input  CH_W  target channel
- in_data  input  DATA_WIDTH  increment value
- clear  input  1  synchronous clear of live bank and sticky flags
- frame_end  input  1  one-cycle pulse; closes the current frame
- out_valid  output  1  snapshot word valid
- out_ready  input  1  downstream accepts word
- out_ch  output  CH_W  channel index of out_data
- out_data  output  ACC_WIDTH  snapshot total
- out_sat  output  1  channel saturated during its frame (0 when saturation is compiled out)
- out_last  output  1  high with channel N_CH-1
- busy  output  1  drain in progress
- overrun  output  1  sticky: a frame_end was dropped

## Operation
- States: IDLE (no drain in progress) and DUMP (snapshot draining).
- Reset: all accumulators, shadow bank, sat bits, out_* outputs, busy and overrun are 0; state is IDLE.
- Live update, in_valid=1 with in_ch < N_CH:
  - acc[in_ch] ← acc[in_ch] + zero-extended in_data.
  - in_ch ≥ N_CH: sample is ignored.
- Arithmetic: modulo 2^ACC_WIDTH, unless saturation is compiled in (see Configuration).
- frame_end in IDLE:
  - Shadow bank ← live bank, with any same-cycle in_valid sample included in the snapshot.
  - Live bank ← 0.
  - State → DUMP with index 0.
- frame_end in DUMP:
  - No snapshot is taken; the live bank keeps accumulating into the next frame.
  - overrun ← 1.
- DUMP:
  - out_valid=1; out_ch=index; out_data/out_sat come from shadow[index].
  - On out_valid & out_ready: index increments.
  - On the beat with index N_CH-1 (out_last=1): state → IDLE.
- clear has priority over in_valid and frame_end in the same cycle:
  - Live bank and live sat bits ← 0.
  - The sample and the frame_end are dropped.
  - overrun ← 0.
  - An in-progress drain and the shadow bank are unaffected.
- busy = (state == DUMP).

## Timing
- Accumulate latency is 1 cycle: a sample at edge T is visible in the live bank after T.
- frame_end accepted at edge T:
  - out_valid=1 with out_ch=0 from T+1.
  - Live bank reads 0 after T; a sample at T+1 is part of the new frame.
- One word per handshake. At full out_ready, a drain takes exactly N_CH cycles.
- While out_valid & ~out_ready, out_ch, out_data, out_sat and out_last hold stable.
- After the last handshake at edge T, busy and out_valid are 0 from T+1. A frame_end at T+1 is accepted.
- A frame_end in the same cycle as the last handshake is in DUMP, so it is dropped and sets overrun.
- arstn assertion mid-drain aborts immediately:
  - All outputs go to 0 asynchronously.
  - Snapshot contents are lost.

## Configuration
- HIST_ACC_SAT_EN defined:
  - Each addition that would exceed 2^ACC_WIDTH-1 clamps to 2^ACC_WIDTH-1.
  - That channel's sat bit is set; the bit is snapshotted with the channel and cleared with it.
- HIST_ACC_SAT_EN undefined:
  - Accumulators wrap modulo 2^ACC_WIDTH.
  - Sat bits are not implemented; out_sat is tied to 0.

## Test plan
- Basic accumulate and drain, N_CH=8, out_ready=1:
  - Stimulus: add 5 to ch 2 three times and 100 to ch 7 once; then frame_end.
  - Expect 8 consecutive beats: ch2=15, ch7=100, all others 0; out_last only on ch 7; busy low after.
- Backpressure:
  - Stimulus: toggle out_ready 1/0 during a drain.
  - Expect out_* stable while stalled; each channel delivered exactly once, in order 0..7.
- Simultaneous events:
  - in_valid (ch 1, +3) with frame_end: the 3 appears in the snapshot; live ch1 reads 0 after.
  - clear with in_valid and frame_end: no drain starts; live bank reads 0.
- Overrun:
  - Stimulus: frame_end while busy, with out_ready=0.
  - Expect overrun=1 and the drain unchanged.
  - Samples from both frames are summed into the next snapshot.
  - A subsequent clear returns overrun to 0.
- Width boundary, ACC_WIDTH=16, DATA_WIDTH=14:
  - Stimulus: add 16383 to ch 0 five times (sum 81915).
  - With HIST_ACC_SAT_EN: drained ch0 value 65535, out_sat=1.
  - Without: drained ch0 value 81915 mod 65536 = 16379, out_sat=0.
- Reset mid-drain:
  - Stimulus: assert arstn low at beat 3.
  - Expect out_valid, busy and overrun at 0 immediately.
  - After release: all-zero live bank; a new frame_end drains all zeros.
